mem_access_unit: RTL and testbench

Data-memory access unit for the MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns load/store control from EX/MEM into a request/grant/response transaction on the data bus, with byte enables and store-lane replication. It returns the sign- or zero-extended load result as `mem_data_mem` and stalls the pipeline until the transaction completes.

---
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data bus access unit (optional MEM_MISALIGN_EXC_EN)
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [ADDR_W-1:0] alu_res_mem,
    input  logic [DATA_W-1:0] store_data_mem,
    input  logic              pipe_hold,
    output logic [DATA_W-1:0] mem_data_mem,
    output logic              stall_mem,
    output logic              misalign_exc,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state_q, state_d;
    logic              access;
    logic              is_byte, is_half;
    logic              misaligned;
    logic [1:0]        lo_now;
    logic [ADDR_W-1:0] addr_now;
    logic [3:0]        be_now;
    logic [DATA_W-1:0] wdata_now;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_fmt;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lo_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] rdata_q;
    logic              misalign_q;

    assign access  = mem_read_mem | mem_write_mem;
    assign is_byte = (funct3_mem[1:0] == 2'b00);
    assign is_half = (funct3_mem[1:0] == 2'b01);

`ifdef MEM_MISALIGN_EXC_EN
    // misaligned halfword/word accesses are trapped instead of issued
    assign lo_now     = alu_res_mem[1:0];
    assign misaligned = (is_half & alu_res_mem[0]) |
                        (~is_byte & ~is_half & (alu_res_mem[1:0] != 2'b00));
    assign misalign_exc = (state_q == DONE) & misalign_q;
`else
    // force natural alignment: halfword drops bit 0, word drops bits 1:0
    assign lo_now       = is_byte ? alu_res_mem[1:0] :
                          is_half ? {alu_res_mem[1], 1'b0} : 2'b00;
    assign misaligned   = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    assign addr_now  = {alu_res_mem[ADDR_W-1:2], 2'b00};
    assign be_now    = is_byte ? (4'b0001 << lo_now) :
                       is_half ? (4'b0011 << {lo_now[1], 1'b0}) : 4'b1111;
    assign wdata_now = is_byte ? {4{store_data_mem[7:0]}} :
                       is_half ? {2{store_data_mem[15:0]}} : store_data_mem;

    // select the addressed lane and extend it according to the load type
    always_comb begin
        lane = dbus_rdata >> {lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'd0, lane[7:0]};
            3'b101:  load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = dbus_rdata;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state, bus request and pipeline stall
    always_comb begin
        state_d   = state_q;
        dbus_req  = 1'b0;
        stall_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_mem = 1'b1;
                    if (misaligned) begin
                        state_d = DONE;
                    end else begin
                        dbus_req = 1'b1;
                        state_d  = dbus_gnt ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                dbus_req  = 1'b1;
                stall_mem = 1'b1;
                if (dbus_gnt) state_d = RESP;
            end
            RESP: begin
                stall_mem = 1'b1;
                if (dbus_rvalid) state_d = DONE;
            end
            DONE: begin
                if (!pipe_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // bus fields come live from the pipeline in IDLE and from the latched copy in REQ
    always_comb begin
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_be    = 4'b0000;
        dbus_wdata = '0;
        if (dbus_req) begin
            if (state_q == IDLE) begin
                dbus_we    = mem_write_mem;
                dbus_addr  = addr_now;
                dbus_be    = be_now;
                dbus_wdata = wdata_now;
            end else begin
                dbus_we    = we_q;
                dbus_addr  = addr_q;
                dbus_be    = be_q;
                dbus_wdata = wdata_q;
            end
        end
    end

    // latch the request at issue and the formatted result on response
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            lo_q       <= 2'b00;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            funct3_q   <= 3'b000;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (state_q == IDLE && access) begin
                addr_q     <= addr_now;
                lo_q       <= lo_now;
                we_q       <= mem_write_mem;
                be_q       <= be_now;
                wdata_q    <= wdata_now;
                funct3_q   <= funct3_mem;
                misalign_q <= misaligned;
                if (misaligned) rdata_q <= '0;
            end
            if (state_q == RESP && dbus_rvalid) begin
                rdata_q <= we_q ? '0 : load_fmt;
            end
        end
    end

    assign mem_data_mem = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_mem, mem_write_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_res_mem, store_data_mem;
    logic        pipe_hold;
    logic [31:0] mem_data_mem;
    logic        stall_mem, misalign_exc;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .funct3_mem(funct3_mem), .alu_res_mem(alu_res_mem),
        .store_data_mem(store_data_mem), .pipe_hold(pipe_hold),
        .mem_data_mem(mem_data_mem), .stall_mem(stall_mem),
        .misalign_exc(misalign_exc), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] prev_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_access(
        input logic rd, input logic wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
        input int gnt_wait, input int rv_wait, input int hold, input logic spur,
        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
        input logic [31:0] e_data, input logic e_mis, input int e_stall);
        exp_t e;
        int   gw, rw, stalls;
        bit   granted, done;
        e.data = e_data; e.mis = e_mis; e.stall = e_stall;
        sb_q.push_back(e);
        @(negedge clk);
        mem_read_mem = rd; mem_write_mem = wr; funct3_mem = f3;
        alu_res_mem = addr; store_data_mem = sd; dbus_rdata = rdata;
        gw = gnt_wait; rw = rv_wait; stalls = 0; granted = 0; done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dbus_gnt = 1'b0;
            dbus_rvalid = spur && !granted;
            if (granted) begin
                if (rw == 0) dbus_rvalid = 1'b1;
                else rw--;
            end
            #1;
            if (dbus_req) begin
                if (gw == 0) dbus_gnt = 1'b1;
                else gw--;
            end
            #1;
            if (stall_mem) begin
                stalls++;
                chk("data_held_in_stall", mem_data_mem, prev_data);
                if (e_mis) chk("misalign_no_req", {31'd0, dbus_req}, 32'd0);
                if (dbus_req) begin
                    chk("bus_addr", dbus_addr, e_addr);
                    chk("bus_be", {28'd0, dbus_be}, {28'd0, e_be});
                    chk("bus_we", {31'd0, dbus_we}, {31'd0, wr});
                    if (wr) chk("bus_wdata", dbus_wdata, e_wdata);
                end
                if (dbus_gnt) granted = 1;
            end else begin
                done = 1;
                e = sb_q.pop_front();
                chk("done_data", mem_data_mem, e.data);
                chk("done_misalign", {31'd0, misalign_exc}, {31'd0, e.mis});
                chk("stall_cycles", stalls, e.stall);
            end
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            e = sb_q.pop_front();
        end
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            pipe_hold = 1'b1;
            @(negedge clk);
            #1;
            chk("hold_stall", {31'd0, stall_mem}, 32'd0);
            chk("hold_no_req", {31'd0, dbus_req}, 32'd0);
            chk("hold_data", mem_data_mem, e.data);
        end
        pipe_hold = 1'b0;
        @(negedge clk);
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall_mem}, 32'd0);
        chk("idle_req", {31'd0, dbus_req}, 32'd0);
        chk("idle_data", mem_data_mem, e.data);
        prev_data = e.data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, mem_data_mem, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_mem}, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign_exc}, 32'd0);
        chk({tag, "_req"}, {31'd0, dbus_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, dbus_we}, 32'd0);
        chk({tag, "_addr"}, dbus_addr, 32'd0);
        chk({tag, "_be"}, {28'd0, dbus_be}, 32'd0);
        chk({tag, "_wdata"}, dbus_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1; mem_read_mem = 1'b0; mem_write_mem = 1'b0; funct3_mem = 3'b000;
        alu_res_mem = 32'd0; store_data_mem = 32'd0; pipe_hold = 1'b0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // LW 0x100, zero-wait slave
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0,
                   32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 2);
        // LB / LBU 0x103
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 0,
                   32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 2);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 0,
                   32'h100, 4'b1000, 32'h0, 32'h00000080, 0, 2);
        // SH 0x102, grant delayed 3 cycles, stray rvalid before the grant
        run_access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 3, 0, 0, 1,
                   32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 0, 5);
        // LH 0x102 with two response wait cycles
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0, 2, 0, 0,
                   32'h100, 4'b1100, 32'h0, 32'hFFFF8012, 0, 4);
        // LHU 0x000 with one grant wait cycle
        run_access(1, 0, 3'b101, 32'h000, 32'h0, 32'h80123456, 1, 0, 0, 0,
                   32'h000, 4'b0011, 32'h0, 32'h00003456, 0, 3);
        // LW with pipe_hold for 2 DONE cycles
        run_access(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0, 0, 2, 0,
                   32'h104, 4'b1111, 32'h0, 32'h12345678, 0, 2);
        // SW 0x108 with grant and response waits
        run_access(0, 1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0,
                   32'h108, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 4);

        // reset while waiting in RESP
        @(negedge clk);
        mem_read_mem = 1'b1; funct3_mem = 3'b010; alu_res_mem = 32'h200;
        dbus_rdata = 32'h55AA55AA;
        #1;
        dbus_gnt = dbus_req;
        #1;
        chk("rst_seq_req", {31'd0, dbus_req}, 32'd1);
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1;
        chk("rst_seq_resp_stall", {31'd0, stall_mem}, 32'd1);
        chk("rst_seq_resp_req", {31'd0, dbus_req}, 32'd0);
        rst = 1'b1; mem_read_mem = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_resp");
        prev_data = 32'd0;

        // SB 0x001 after reset
        run_access(0, 1, 3'b000, 32'h001, 32'h0000005A, 32'h0, 0, 0, 0, 0,
                   32'h000, 4'b0010, 32'h5A5A5A5A, 32'h0, 0, 2);

        // LW at misaligned 0x102
`ifdef MEM_MISALIGN_EXC_EN
        run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 0, 0, 0, 0,
                   32'h100, 4'b1111, 32'h0, 32'h0, 1, 1);
`else
        run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 0, 0, 0, 0,
                   32'h100, 4'b1111, 32'h0, 32'h0BADF00D, 0, 2);
`endif

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
